// File: rtl/sfp_tx_arb_n.sv
// N-channel store-and-forward transmit arbiter: per-channel packet FIFOs with
// drop-on-overflow, merged round-robin onto one byte stream with an inter-frame gap.
module sfp_tx_arb_n #(
   parameter int CH_NUM       = 2,
   parameter int DW           = 8,
   parameter int ADDR_W       = 11,
   parameter int PROG_FULL_TH = 1536,
   parameter int IFG          = 12,
   localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                   tx_clk,
   input  logic                   tx_rst,
   input  logic [CH_NUM*DW-1:0]   din,
   input  logic [CH_NUM-1:0]      din_en,
   output logic [CH_NUM-1:0]      prog_full,
   output logic [CH_NUM-1:0]      drop,
   output logic [DW-1:0]          dout,
   output logic                   dout_en,
   output logic [CH_W-1:0]        dout_ch
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int PW    = ADDR_W + 1;
   localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG > 0) ? IFG - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t                      state;
   logic [CH_W-1:0]             sel;
   logic [CH_W-1:0]             last_ch;
   logic [CH_W-1:0]             pick;
   logic                        found;
   logic [PW-1:0]               rd_addr;
   logic                        rd_vld;
   logic [GAP_W-1:0]            gap_cnt;

   logic [CH_NUM-1:0]           eligible;
   logic [CH_NUM-1:0][PW-1:0]   rd_ptr_w;
   logic [CH_NUM-1:0][DW:0]     ram_q_w;
   logic [DW:0]                 rd_q;
   logic                        pop;

   assign rd_q = ram_q_w[sel];
   assign pop  = rd_vld & rd_q[DW];

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic [DW-1:0] din_q;
      logic          din_en_q;
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] commit_ptr;
      logic [PW-1:0] rd_ptr;
      logic [PW-1:0] occ;
      logic [PW-1:0] pkt_cnt;
      logic          dropping;
      logic          full;
      logic          wr_last;
      logic          we;
      logic          commit;
      logic          consume;
      logic          pop_c;
      logic          drop_q;
      logic          prog_full_q;
      logic [DW:0]   mem [DEPTH];
      logic [DW:0]   ram_q;

      assign occ     = wr_ptr - rd_ptr;
      assign full    = (occ == PW'(DEPTH));
      assign wr_last = ~din_en[c];
      assign we      = din_en_q & ~dropping & ~full;
      assign commit  = we & wr_last;
      assign consume = rd_vld & (sel == CH_W'(c));
      assign pop_c   = consume & rd_q[DW];

      // A packet that hits a full FIFO is swallowed to its end, then the
      // write pointer rolls back to the last committed packet boundary.
      always_ff @(posedge tx_clk or posedge tx_rst) begin
         if (tx_rst) begin
            din_q      <= '0;
            din_en_q   <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            dropping   <= 1'b0;
            drop_q     <= 1'b0;
         end else begin
            din_q    <= din[c*DW +: DW];
            din_en_q <= din_en[c];
            drop_q   <= 1'b0;
            if (din_en_q) begin
               if (dropping | full) begin
                  if (wr_last) begin
                     wr_ptr   <= commit_ptr;
                     drop_q   <= 1'b1;
                     dropping <= 1'b0;
                  end else begin
                     dropping <= 1'b1;
                  end
               end else begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (wr_last) begin
                     commit_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
         end
      end

      always_ff @(posedge tx_clk or posedge tx_rst) begin
         if (tx_rst) begin
            rd_ptr      <= '0;
            pkt_cnt     <= '0;
            prog_full_q <= 1'b0;
         end else begin
            if (consume) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (commit & ~pop_c) begin
               pkt_cnt <= pkt_cnt + 1'b1;
            end else if (~commit & pop_c) begin
               pkt_cnt <= pkt_cnt - 1'b1;
            end
            prog_full_q <= (occ >= PW'(PROG_FULL_TH));
         end
      end

      // Each byte carries its end-of-packet flag in the extra MSB.
      always_ff @(posedge tx_clk) begin
         if (we) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, din_q};
         end
         ram_q <= mem[rd_addr[ADDR_W-1:0]];
      end

      assign eligible[c]  = (pkt_cnt != '0);
      assign rd_ptr_w[c]  = rd_ptr;
      assign ram_q_w[c]   = ram_q;
      assign prog_full[c] = prog_full_q;
      assign drop[c]      = drop_q;
   end

   logic [CH_W-1:0] idx;

   // Round-robin search starting just after the previously granted channel.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 1; i <= CH_NUM; i++) begin
         idx = CH_W'((int'(last_ch) + i) % CH_NUM);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // The read address runs one byte ahead of consumption; the read issued
   // alongside the returning last byte is simply discarded.
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state   <= IDLE;
         sel     <= '0;
         last_ch <= CH_W'(CH_NUM - 1);
         rd_addr <= '0;
         rd_vld  <= 1'b0;
         gap_cnt <= '0;
         dout    <= '0;
         dout_en <= 1'b0;
         dout_ch <= '0;
      end else begin
         dout_en <= rd_vld;
         if (rd_vld) begin
            dout    <= rd_q[DW-1:0];
            dout_ch <= sel;
         end
         rd_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  sel     <= pick;
                  last_ch <= pick;
                  rd_addr <= rd_ptr_w[pick];
                  state   <= SEND;
               end
            end
            SEND: begin
               if (pop) begin
                  gap_cnt <= '0;
                  state   <= (IFG == 0) ? IDLE : GAP;
               end else begin
                  rd_vld  <= 1'b1;
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfp_tx_arb_n.sv
// Directed bench for sfp_tx_arb_n: a default instance and a small-FIFO instance
// with a long gap, checked against a byte scoreboard and cycle-exact probes.
module tb_sfp_tx_arb_n;

   logic        tx_clk = 1'b0;
   logic        rst_a, rst_b;
   logic [15:0] din_a, din_b;
   logic [1:0]  din_en_a, din_en_b;
   logic [1:0]  prog_full_a, prog_full_b, drop_a, drop_b;
   logic [7:0]  dout_a, dout_b;
   logic        dout_en_a, dout_en_b;
   logic [0:0]  dout_ch_a, dout_ch_b;

   always #5 tx_clk = ~tx_clk;

   sfp_tx_arb_n #(.CH_NUM(2), .DW(8), .ADDR_W(11), .PROG_FULL_TH(1536), .IFG(12)) dut_a (
      .tx_clk(tx_clk), .tx_rst(rst_a), .din(din_a), .din_en(din_en_a),
      .prog_full(prog_full_a), .drop(drop_a), .dout(dout_a), .dout_en(dout_en_a), .dout_ch(dout_ch_a)
   );

   sfp_tx_arb_n #(.CH_NUM(2), .DW(8), .ADDR_W(6), .PROG_FULL_TH(40), .IFG(100)) dut_b (
      .tx_clk(tx_clk), .tx_rst(rst_b), .din(din_b), .din_en(din_en_b),
      .prog_full(prog_full_b), .drop(drop_b), .dout(dout_b), .dout_en(dout_en_b), .dout_ch(dout_ch_b)
   );

   int cyc = 0;
   always @(posedge tx_clk) cyc <= cyc + 1;

   logic [8:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
   int gaps_a[$], runs_a[$];
   int low_a = 1000, run_a = 0, rise_cyc_a = 0;
   int drops_a = 0, drops_b0 = 0, drops_b1 = 0;
   logic prev_a = 1'b0;
   int vectors = 0, miscompares = 0;

   // Output capture: bytes for the scoreboard, plus idle-gap and run lengths.
   always @(negedge tx_clk) begin
      if (dout_en_a) begin
         obs_a.push_back({dout_ch_a, dout_a});
         if (!prev_a) begin
            gaps_a.push_back(low_a);
            rise_cyc_a = cyc;
            run_a = 0;
         end
         run_a++;
         low_a = 0;
      end else begin
         if (prev_a) runs_a.push_back(run_a);
         low_a++;
      end
      prev_a = dout_en_a;
      if (dout_en_b) obs_b.push_back({dout_ch_b, dout_b});
      drops_a  += $countones(drop_a);
      drops_b0 += int'(drop_b[0]);
      drops_b1 += int'(drop_b[1]);
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit inst, input logic [1:0] mask, input int len, input int base,
                                input bit push, output int last_cyc);
      logic [7:0] b;
      logic [0:0] ch;
      last_cyc = cyc;
      for (int i = 0; i < len; i++) begin
         @(negedge tx_clk);
         for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
               b = 8'(base + c * 128 + i);
               if (inst) begin
                  din_b[c*8 +: 8] = b;
                  din_en_b[c] = 1'b1;
               end else begin
                  din_a[c*8 +: 8] = b;
                  din_en_a[c] = 1'b1;
               end
            end
         end
         last_cyc = cyc;
      end
      @(negedge tx_clk);
      if (inst) din_en_b = din_en_b & ~mask;
      else      din_en_a = din_en_a & ~mask;
      if (push) begin
         for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
               ch = 1'(c);
               for (int i = 0; i < len; i++) begin
                  b = 8'(base + c * 128 + i);
                  if (inst) exp_b.push_back({ch, b});
                  else      exp_a.push_back({ch, b});
               end
            end
         end
      end
   endtask

   task automatic checkStream(input bit inst, input string tag);
      int n, waited, got;
      logic [8:0] e, o;
      n = inst ? exp_b.size() : exp_a.size();
      waited = 0;
      got = inst ? obs_b.size() : obs_a.size();
      while (got < n && waited < 20 * n + 500) begin
         @(negedge tx_clk);
         waited++;
         got = inst ? obs_b.size() : obs_a.size();
      end
      vectors++;
      assert (got >= n) else begin
         miscompares++;
         $error("[TB] FAIL %s timeout: observed %0d bytes expected %0d", tag, got, n);
      end
      for (int i = 0; i < n; i++) begin
         if (inst) begin
            e = exp_b.pop_front();
            o = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
         end else begin
            e = exp_a.pop_front();
            o = (obs_a.size() > 0) ? obs_a.pop_front() : 'x;
         end
         vectors++;
         assert (o === e) else begin
            miscompares++;
            $error("[TB] FAIL %s byte %0d: observed %h expected %h", tag, i, o, e);
         end
      end
   endtask

   int lc;

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      din_a = '0; din_b = '0; din_en_a = '0; din_en_b = '0;
      repeat (3) @(negedge tx_clk);
      checkOutput("reset dout", dout_a, 0);
      checkOutput("reset dout_en", dout_en_a, 0);
      checkOutput("reset dout_ch", dout_ch_a, 0);
      checkOutput("reset prog_full", prog_full_a, 0);
      checkOutput("reset drop", drop_a, 0);
      checkOutput("reset dout_en b", dout_en_b, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) @(negedge tx_clk);

      $display("[TB] single 64-byte packet on ch0");
      applyStimulus(0, 2'b01, 64, 0, 1, lc);
      checkStream(0, "t1 stream");
      repeat (2) @(negedge tx_clk);
      checkOutput("t1 run length", (runs_a.size() > 0) ? runs_a[$] : -1, 64);
      checkOutput("t1 latency", rise_cyc_a - lc, 5);
      checkOutput("t1 drops", drops_a, 0);

      $display("[TB] prog_full threshold crossing");
      applyStimulus(0, 2'b01, 1536, 8'h40, 1, lc);
      @(negedge tx_clk);
      checkOutput("pf before rise", prog_full_a[0], 0);
      @(negedge tx_clk);
      checkOutput("pf rise", prog_full_a[0], 1);
      repeat (2) @(negedge tx_clk);
      checkOutput("pf hold", prog_full_a[0], 1);
      @(negedge tx_clk);
      checkOutput("pf fall", prog_full_a[0], 0);
      checkStream(0, "pf stream");

      $display("[TB] reset during output");
      applyStimulus(0, 2'b01, 200, 8'h20, 0, lc);
      repeat (50) @(negedge tx_clk);
      checkOutput("rst mid-packet dout_en", dout_en_a, 1);
      rst_a = 1'b1;
      #1;
      checkOutput("rst async dout_en", dout_en_a, 0);
      checkOutput("rst async dout", dout_a, 0);
      repeat (2) @(negedge tx_clk);
      rst_a = 1'b0;
      obs_a.delete();
      applyStimulus(0, 2'b10, 10, 8'h55, 1, lc);
      checkStream(0, "rst ch1 stream");
      repeat (150) @(negedge tx_clk);
      checkOutput("rst no stale bytes", obs_a.size(), 0);

      $display("[TB] round robin, three packets per channel");
      gaps_a.delete();
      for (int r = 0; r < 3; r++) applyStimulus(0, 2'b11, 100, r * 16, 1, lc);
      checkStream(0, "rr stream");
      repeat (2) @(negedge tx_clk);
      checkOutput("rr packet count", gaps_a.size(), 6);
      for (int i = 1; i < 6; i++) checkOutput("rr gap", (gaps_a.size() > i) ? gaps_a[i] : -1, 14);

      $display("[TB] oversize packet on small FIFO");
      applyStimulus(1, 2'b01, 65, 8'h70, 0, lc);
      checkOutput("oversize drop early", drop_b, 0);
      @(negedge tx_clk);
      checkOutput("oversize drop pulse", drop_b, 2'b01);
      @(negedge tx_clk);
      checkOutput("oversize drop end", drop_b, 0);
      applyStimulus(1, 2'b01, 10, 8'h90, 1, lc);
      checkStream(1, "after oversize");

      $display("[TB] overflow while output blocked");
      applyStimulus(1, 2'b10, 4, 8'h11, 1, lc);
      checkStream(1, "blocker ch1");
      applyStimulus(1, 2'b01, 40, 8'h30, 1, lc);
      applyStimulus(1, 2'b01, 30, 8'hA0, 0, lc);
      @(negedge tx_clk);
      checkOutput("overflow drop pulse", drop_b, 2'b01);
      checkOutput("overflow prog_full", prog_full_b[0], 1);
      checkStream(1, "first packet intact");
      applyStimulus(1, 2'b01, 10, 8'hC0, 1, lc);
      checkStream(1, "after rollback");
      repeat (4) @(negedge tx_clk);
      checkOutput("small prog_full idle", prog_full_b, 0);
      checkOutput("small ch0 drop count", drops_b0, 2);
      checkOutput("small ch1 drop count", drops_b1, 0);
      checkOutput("default drop count", drops_a, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
